thunderbird_input_cond: RTL and testbench
=========================================

Name: thunderbird_input_cond

Overview:
Upstream conditioning stage for the thunderbird tail-light FSM, running on the fast board clock `Clk`.
- Synchronises and debounces the raw left, right and hazard switches.
- Arbitrates them through a small FSM.
- Drives clean, glitch-free `left`/`right` levels into the light sequencer; hazard is encoded as both levels high.
- Outputs are static levels, so the sequencer running on the divided clock enable samples them safely.

Parameters:
- DEBOUNCE_CYCLES, default 250000: consecutive stable `Clk` cycles required before a debounced input changes. Legal range ≥ 1.
- CNT_W, default 18: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- raw_left  input  1  asynchronous, bouncy left-turn switch.
- raw_right  input  1  asynchronous, bouncy right-turn switch.
- raw_hazard  input  1  asynchronous, bouncy hazard switch.
- left  output  1  clean left request to the light sequencer.
- right  output  1  clean right request to the light sequencer.
- hazard  output  1  high while the FSM is in HAZARD (status/LED).
- state_o  output  2  FSM state: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are `Clk` and `reset`.
- Reset values: on any edge with reset=1, the following are forced to 0:
  - sync flops, debounced values db_*, counters;
  - state (IDLE), hence left=right=hazard=0, state_o=0.
  - Reset mid-debounce or mid-state discards all progress.
- Synchroniser: two flops per input, s1 then s2. No other logic touches raw_*.
- Debounce, per channel:
  - If s2 == db: counter cleared to 0.
  - Otherwise counter increments. On the edge where it would reach DEBOUNCE_CYCLES: db <= s2 and counter <= 0.
  - Any return of s2 to db before that point clears the counter, so glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a clean raw step held stable produces the state change on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples it.
  - Edges 1–2: synchroniser.
  - Edges 3 to DEBOUNCE_CYCLES+2: counting; db updates on edge DEBOUNCE_CYCLES+2.
  - Edge DEBOUNCE_CYCLES+3: FSM state updates.
- FSM, evaluated from db_* (or hz_eff, see Optional Feature) every cycle:
  - IDLE:
    - hz_eff → HAZARD.
    - else db_left & !db_right → LEFT.
    - else db_right & !db_left → RIGHT.
    - else (both or neither) stay IDLE.
  - LEFT: hz_eff → HAZARD; else !db_left → IDLE. db_right is ignored (first-come lock).
  - RIGHT: symmetric to LEFT.
  - HAZARD: !hz_eff → IDLE. New direction requests are evaluated the following cycle from IDLE.
- Outputs are decoded combinationally from the state register only, never from inputs:
  - left = (state==LEFT | state==HAZARD)
  - right = (state==RIGHT | state==HAZARD)
  - hazard = (state==HAZARD)
  - No glitches.
- Transition LEFT→RIGHT always passes through one IDLE cycle, with both outputs 0 for at least one `Clk` cycle.

Optional Feature:
Macro HAZARD_LATCH_EN.
- Defined:
  - A rising edge of db_hazard (db_hazard=1, previous value 0) toggles register hz_latch (reset 0).
  - hz_eff = hz_latch, so a press-and-release enters HAZARD and a second press exits it.
  - Toggles take effect on the edge after the db change.
- Undefined: hz_eff = db_hazard, a momentary level with no extra register.

Test Plan:
1. DEBOUNCE_CYCLES=4, raw_left high held → left=1, state_o=1 exactly 7 edges after first sample; right=0 throughout.
2. raw_left pulses high for 3 cycles (< DEBOUNCE_CYCLES=4), repeated bounce pattern 1-0-1-0 → left stays 0, state_o stays 0.
3. Left established, then raw_right high held → state stays LEFT. Release left → IDLE for exactly 1 cycle (left=right=0), then RIGHT (right=1).
4. LEFT active, raw_hazard held → HAZARD, left=right=hazard=1. Release hazard → IDLE then LEFT again if left still held.
5. reset asserted for 1 cycle while in HAZARD with a counter mid-count → next edge all outputs 0, state_o=0. Fresh DEBOUNCE_CYCLES+3 latency applies after release.
6. HAZARD_LATCH_EN defined: one hazard press/release → HAZARD persists after release. Second press → IDLE. Undefined build → HAZARD exits on release.

Source files
------------

// File: rtl/thunderbird_input_cond.sv
// thunderbird_input_cond: synchronises, debounces and arbitrates the raw
// left/right/hazard switches into clean static left/right levels for the
// tail-light sequencer. Optional macro HAZARD_LATCH_EN turns the hazard
// switch into a press-to-toggle control instead of a momentary level.

// Per-channel two-flop synchroniser plus stable-count debouncer.
module thunderbird_input_cond_db #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic Clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  // Sync the raw level, then accept it once it has differed from db long enough.
  always_ff @(posedge Clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module thunderbird_input_cond #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       raw_left,
  input  logic       raw_right,
  input  logic       raw_hazard,
  output logic       left,
  output logic       right,
  output logic       hazard,
  output logic [1:0] state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2, HAZARD = 2'd3} state_t;

  // Channel order: 0 = left, 1 = right, 2 = hazard.
  logic [2:0] raw_vec;
  logic [2:0] db_vec;
  logic       db_left, db_right, db_hazard;
  logic       hz_eff;
  state_t     state, state_nxt;

  assign raw_vec = {raw_hazard, raw_right, raw_left};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    thunderbird_input_cond_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .Clk  (Clk),
      .reset(reset),
      .raw  (raw_vec[c]),
      .db   (db_vec[c])
    );
  end

  assign db_left   = db_vec[0];
  assign db_right  = db_vec[1];
  assign db_hazard = db_vec[2];

`ifdef HAZARD_LATCH_EN
  logic hz_latch, db_hazard_q;

  // Each debounced hazard press flips the latch; the latch drives arbitration.
  always_ff @(posedge Clk) begin
    if (reset) begin
      hz_latch    <= 1'b0;
      db_hazard_q <= 1'b0;
    end else begin
      db_hazard_q <= db_hazard;
      if (db_hazard && !db_hazard_q) hz_latch <= ~hz_latch;
    end
  end

  assign hz_eff = hz_latch;
`else
  assign hz_eff = db_hazard;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Arbitration: hazard wins; a granted direction holds until released,
  // so a direction swap always passes through IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hz_eff)                    state_nxt = HAZARD;
        else if (db_left && !db_right) state_nxt = LEFT;
        else if (db_right && !db_left) state_nxt = RIGHT;
      end
      LEFT: begin
        if (hz_eff)         state_nxt = HAZARD;
        else if (!db_left)  state_nxt = IDLE;
      end
      RIGHT: begin
        if (hz_eff)         state_nxt = HAZARD;
        else if (!db_right) state_nxt = IDLE;
      end
      HAZARD: begin
        if (!hz_eff)        state_nxt = IDLE;
      end
      default:              state_nxt = IDLE;
    endcase
  end

  // Outputs come from the state register only, so they are glitch-free levels.
  assign left    = (state == LEFT)  || (state == HAZARD);
  assign right   = (state == RIGHT) || (state == HAZARD);
  assign hazard  = (state == HAZARD);
  assign state_o = state;
endmodule

// File: tb/tb_thunderbird_input_cond.sv
module tb_thunderbird_input_cond;
  localparam int DC = 4;
  localparam int CW = 3;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_left = 1'b0, raw_right = 1'b0, raw_hazard = 1'b0;
  logic       left, right, hazard;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  thunderbird_input_cond #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .raw_left  (raw_left),
    .raw_right (raw_right),
    .raw_hazard(raw_hazard),
    .left      (left),
    .right     (right),
    .hazard    (hazard),
    .state_o   (state_o)
  );

  always #5 Clk = ~Clk;

  // Reference model: the synchroniser is a two-sample delay; a debounced bit
  // flips once the last DC synchronised samples all disagree with it.
  bit [2:0] m_s1, m_s2, m_db;
  bit [2:0] win[$];
  int       m_state;
  bit       m_hzl, m_dbh_prev;
  int       cyc = 0;

  task automatic model_edge(input bit rst, input bit [2:0] raw);
    bit       hz;
    int       ns;
    bit [2:0] ndb;
    bit       all_diff;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; win.delete();
      m_state = 0; m_hzl = 0; m_dbh_prev = 0;
      return;
    end
`ifdef HAZARD_LATCH_EN
    hz = m_hzl;
`else
    hz = m_db[2];
`endif
    ns = m_state;
    if (m_state == 0) begin
      if (hz) ns = 3;
      else if (m_db[0] && !m_db[1]) ns = 1;
      else if (m_db[1] && !m_db[0]) ns = 2;
    end else if (m_state == 1) begin
      ns = hz ? 3 : (!m_db[0] ? 0 : 1);
    end else if (m_state == 2) begin
      ns = hz ? 3 : (!m_db[1] ? 0 : 2);
    end else begin
      ns = hz ? 3 : 0;
    end
    if (m_db[2] && !m_dbh_prev) m_hzl = !m_hzl;
    m_dbh_prev = m_db[2];
    win.push_back(m_s2);
    if (win.size() > DC) void'(win.pop_front());
    ndb = m_db;
    if (win.size() == DC) begin
      for (int c = 0; c < 3; c++) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i][c] == m_db[c]) all_diff = 1'b0;
        if (all_diff) ndb[c] = !m_db[c];
      end
    end
    m_db    = ndb;
    m_s2    = m_s1;
    m_s1    = raw;
    m_state = ns;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic step(input bit rst, input bit [2:0] raw);
    logic [4:0] exp, got;
    reset = rst; raw_left = raw[0]; raw_right = raw[1]; raw_hazard = raw[2];
    @(posedge Clk);
    model_edge(rst, raw);
    cyc++;
    #1;
    exp = {2'(m_state), (m_state == 1 || m_state == 3), (m_state == 2 || m_state == 3), (m_state == 3)};
    got = {state_o, left, right, hazard};
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL model cycle=%0d observed=%b expected=%b", cyc, got, exp);
    end
  endtask

  task automatic wait_state(input string tag, input bit [2:0] raw, input int st);
    for (int i = 0; i < 20 && state_o != 2'(st); i++) step(0, raw);
    chk(tag, int'(state_o), st);
  endtask

  initial begin
    bit [2:0] r;
    // Reset state
    step(1, 3'b000);
    step(1, 3'b000);
    chk("reset_state", int'({state_o, left, right, hazard}), 0);

    // 1: latency of a clean left step is DC+3 edges
    for (int k = 1; k <= DC + 3; k++) begin
      step(0, 3'b001);
      if (k == DC + 2) chk("lat_before", int'(state_o), 0);
      chk("lat_right_low", int'(right), 0);
    end
    chk("lat_state", int'(state_o), 1);
    chk("lat_left", int'(left), 1);

    // 2: bounces shorter than DC never propagate
    for (int k = 0; k < 10; k++) step(0, 3'b000);
    chk("idle_again", int'(state_o), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 3'b001); step(0, 3'b001); step(0, 3'b001); step(0, 3'b000);
      chk("glitch_left", int'(left), 0);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 3'b001); step(0, 3'b000);
      chk("bounce_state", int'(state_o), 0);
    end
    for (int k = 0; k < 8; k++) step(0, 3'b000);

    // 3: first-come lock, then a direction swap passes through one IDLE cycle
    wait_state("t3_left", 3'b001, 1);
    for (int k = 0; k < 10; k++) step(0, 3'b011);
    chk("t3_lock", int'(state_o), 1);
    wait_state("t3_idle", 3'b010, 0);
    chk("t3_idle_out", int'({left, right}), 0);
    step(0, 3'b010);
    chk("t3_right", int'(state_o), 2);
    chk("t3_right_out", int'({left, right}), 1);
    for (int k = 0; k < 10; k++) step(0, 3'b000);

    // 4: hazard over an active left, then back to left through IDLE
    wait_state("t4_left", 3'b001, 1);
    wait_state("t4_hazard", 3'b101, 3);
    chk("t4_outs", int'({left, right, hazard}), 7);
`ifdef HAZARD_LATCH_EN
    // 6: latched hazard survives release, second press exits
    for (int k = 0; k < 12; k++) step(0, 3'b001);
    chk("t6_persist", int'(state_o), 3);
    for (int k = 0; k < 8; k++) step(0, 3'b101);
    wait_state("t6_exit", 3'b001, 0);
    step(0, 3'b001);
    chk("t6_left", int'(state_o), 1);
`else
    // 6: momentary hazard exits on release
    wait_state("t4_idle", 3'b001, 0);
    step(0, 3'b001);
    chk("t4_left_again", int'(state_o), 1);
`endif

    // 5: reset mid-state with a counter mid-count discards everything
    wait_state("t5_hazard", 3'b101, 3);
    step(0, 3'b111); step(0, 3'b111); step(0, 3'b111); step(0, 3'b111);
    step(1, 3'b001);
    chk("t5_reset_out", int'({state_o, left, right, hazard}), 0);
    for (int k = 1; k <= DC + 3; k++) begin
      step(0, 3'b001);
      if (k == DC + 2) chk("t5_lat_before", int'(state_o), 0);
    end
    chk("t5_lat_state", int'(state_o), 1);

    // Randomised toggling with occasional resets, checked every cycle by the model
    r = 3'b000;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 3; c++) if ($urandom_range(0, 5) == 0) r[c] = !r[c];
      step($urandom_range(0, 299) == 0, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
